comparator_bist: RTL and testbench

Self-test controller for the comparator family: the stimulus-and-check end of the comparator interface. On `start` it drives every `{a,b}` vector into a comparator under test. It samples the `e/g/l` response after a configurable settle time and compares it with a golden model. It then reports pass/fail and an error count. It sits beside a comparator instance, replacing a simulation-only testbench with synthesizable self-test.

---
 rtl/comparator_bist_pkg.sv | 20 ++
 rtl/comparator_bist_if.sv | 15 +
 rtl/comparator_golden.sv | 16 +
 rtl/comparator_bist.sv | 170 +++++++++++++++++
 tb/tb_comparator_bist.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/comparator_bist_pkg.sv
// rtl/comparator_bist_pkg.sv - shared state encoding and limits for the comparator BIST
package comparator_bist_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Largest supported operand width and settle time
  localparam int MAX_WIDTH  = 4;
  localparam int MAX_SETTLE = 15;

  // Bits needed to hold a settle count up to MAX_SETTLE
  localparam int SETTLE_CNT_W = $clog2(MAX_SETTLE + 1);

endpackage

// File: rtl/comparator_bist_if.sv
// rtl/comparator_bist_if.sv - operand/response bus between the BIST and a comparator under test
interface comparator_bist_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e;
  logic             g;
  logic             l;

  // BIST side drives operands and observes the response
  modport master (output a, output b, input e, input g, input l);
  // Comparator side consumes operands and drives the response
  modport slave  (input a, input b, output e, output g, output l);
endinterface

// File: rtl/comparator_golden.sv
// rtl/comparator_golden.sv - combinational unsigned reference comparator
module comparator_golden #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             e_o,
  output logic             g_o,
  output logic             l_o
);

  assign e_o = (a_i == b_i);
  assign g_o = (a_i >  b_i);
  assign l_o = (a_i <  b_i);

endmodule

// File: rtl/comparator_bist.sv
// rtl/comparator_bist.sv - exhaustive self-test of a comparator; COMPARATOR_BIST_FAILLOG_EN adds first-fail capture
module comparator_bist
  import comparator_bist_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [2*WIDTH:0]   err_count_o,
`ifdef COMPARATOR_BIST_FAILLOG_EN
  output logic [WIDTH-1:0]   fail_a_o,
  output logic [WIDTH-1:0]   fail_b_o,
  output logic               fail_valid_o,
`endif
  comparator_bist_if.master  cmp
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = SETTLE_CNT_W;
  localparam logic [VW-1:0] LAST_VEC = '1;

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_APPLY = APPLY;
  localparam logic [2:0] ST_WAIT  = WAIT;
  localparam logic [2:0] ST_CHECK = CHECK;
  localparam logic [2:0] ST_DONE  = DONE;

  logic [2:0]    state_q, state_d;
  logic [VW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   err_q, err_d;
  logic          pass_q, pass_d;

  logic [WIDTH-1:0] a_w, b_w;
  logic             gold_e, gold_g, gold_l;
  logic             mismatch;

`ifdef COMPARATOR_BIST_FAILLOG_EN
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             fail_valid_q, fail_valid_d;

  assign fail_a_o     = fail_a_q;
  assign fail_b_o     = fail_b_q;
  assign fail_valid_o = fail_valid_q;
`endif

  comparator_golden #(.WIDTH(WIDTH)) u_golden (
    .a_i (a_w),
    .b_i (b_w),
    .e_o (gold_e),
    .g_o (gold_g),
    .l_o (gold_l)
  );

  // Operands come straight from the vector index while a run is active, zero when idle
  always_comb begin
    a_w = '0;
    b_w = '0;
    if (state_q != ST_IDLE) begin
      {a_w, b_w} = idx_q;
    end
  end

  assign cmp.a    = a_w;
  assign cmp.b    = b_w;
  assign mismatch = ({cmp.e, cmp.g, cmp.l} != {gold_e, gold_g, gold_l});

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign pass_o      = pass_q;
  assign err_count_o = err_q;

  // Next-state: walk every {a,b} vector, settle, then score the response
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
`ifdef COMPARATOR_BIST_FAILLOG_EN
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_valid_d = fail_valid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_APPLY;
          idx_d   = '0;
          err_d   = '0;
          pass_d  = 1'b0;
`ifdef COMPARATOR_BIST_FAILLOG_EN
          fail_a_d     = '0;
          fail_b_d     = '0;
          fail_valid_d = 1'b0;
`endif
        end
      end
      ST_APPLY: begin
        cnt_d   = CW'(SETTLE);
        state_d = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
      end
      ST_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_CHECK: begin
        err_d = err_q + {{VW{1'b0}}, mismatch};
`ifdef COMPARATOR_BIST_FAILLOG_EN
        if (mismatch && !fail_valid_q) begin
          fail_a_d     = a_w;
          fail_b_d     = b_w;
          fail_valid_d = 1'b1;
        end
`endif
        if (idx_q == LAST_VEC) begin
          state_d = ST_DONE;
          // Verdict includes this final vector's increment
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + VW'(1);
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
`ifdef COMPARATOR_BIST_FAILLOG_EN
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
`ifdef COMPARATOR_BIST_FAILLOG_EN
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_valid_q <= fail_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_comparator_bist.sv
// tb/tb_comparator_bist.sv - self-checking bench for comparator_bist (WIDTH=1/SETTLE=1 and WIDTH=2/SETTLE=0)
module tb_comparator_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start2;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  logic       busy2, done2, pass2;
  logic [4:0] err2;
`ifdef COMPARATOR_BIST_FAILLOG_EN
  logic       fa1, fb1, fv1;
  logic [1:0] fa2, fb2;
  logic       fv2;
`endif

  comparator_bist_if #(.WIDTH(1)) bus1 ();
  comparator_bist_if #(.WIDTH(2)) bus2 ();

  comparator_bist #(.WIDTH(1), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(err1),
`ifdef COMPARATOR_BIST_FAILLOG_EN
    .fail_a_o(fa1), .fail_b_o(fb1), .fail_valid_o(fv1),
`endif
    .cmp(bus1)
  );

  comparator_bist #(.WIDTH(2), .SETTLE(0)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err2),
`ifdef COMPARATOR_BIST_FAILLOG_EN
    .fail_a_o(fa2), .fail_b_o(fb2), .fail_valid_o(fv2),
`endif
    .cmp(bus2)
  );

  // Behavioural comparator-under-test models with selectable faults
  int         mode1 = 0;
  int         mode2 = 0;
  logic [2:0] flt2 [16];
  logic [2:0] r1, r2;

  function automatic logic [2:0] golden(input int a, input int b);
    return {a == b, a > b, a < b};
  endfunction

  function automatic logic [2:0] model(input int mode, input int a, input int b, input logic [2:0] flt);
    logic [2:0] r;
    r = golden(a, b);
    case (mode)
      1: r[1] = 1'b0;
      2: r = 3'b111;
      3: r[0] = 1'b0;
      4: r[2] = 1'b1;
      5: r = r ^ flt;
      default: ;
    endcase
    return r;
  endfunction

  always_comb r1 = model(mode1, int'(bus1.a), int'(bus1.b), 3'b000);
  always_comb r2 = model(mode2, int'(bus2.a), int'(bus2.b), flt2[{bus2.a, bus2.b}]);
  assign bus1.e = r1[2];
  assign bus1.g = r1[1];
  assign bus1.l = r1[0];
  assign bus2.e = r2[2];
  assign bus2.g = r2[1];
  assign bus2.l = r2[0];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full run: records done edge, done count, busy-fall edge, operand sequence errors
  task automatic run(input int sel, output int done_at, output int ndone, output int idle_at,
                     output int ab_bad, output int pass0, output int busy0);
    int n, s, e, v;
    logic [3:0] ab;
    n = (sel == 0) ? 4 : 16;
    s = (sel == 0) ? 1 : 0;
    done_at = -1; ndone = 0; idle_at = -1; ab_bad = 0; pass0 = -1; busy0 = -1;
    @(negedge clk);
    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    e = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (e == 0) begin
        pass0 = (sel == 0) ? int'(pass1) : int'(pass2);
        busy0 = (sel == 0) ? int'(busy1) : int'(busy2);
      end
      if (e < n * (s + 2)) begin
        v  = e / (s + 2);
        ab = (sel == 0) ? {2'b00, bus1.a, bus1.b} : {bus2.a, bus2.b};
        if (int'(ab) != v) ab_bad++;
      end
      if ((sel == 0) ? done1 : done2) begin
        ndone++;
        done_at = e;
      end
      if (done_at >= 0 && !((sel == 0) ? busy1 : busy2)) begin
        idle_at = e;
        break;
      end
      @(posedge clk);
      e++;
    end
  endtask

  typedef struct {
    int mode;
    int err;
    int pass;
    int fa;
    int fb;
    int fv;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int done_at, ndone, idle_at, ab_bad, pass0, busy0;
    int exp_err, first_v, e;

    tbl[0] = '{mode: 0, err: 0, pass: 1, fa: 0, fb: 0, fv: 0};
    tbl[1] = '{mode: 1, err: 1, pass: 0, fa: 1, fb: 0, fv: 1};
    tbl[2] = '{mode: 2, err: 4, pass: 0, fa: 0, fb: 0, fv: 1};
    tbl[3] = '{mode: 3, err: 1, pass: 0, fa: 0, fb: 1, fv: 1};
    tbl[4] = '{mode: 4, err: 2, pass: 0, fa: 0, fb: 1, fv: 1};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 16; i++) flt2[i] = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_pass1", int'(pass1), 0);
    chk("rst_ab1", int'({bus1.a, bus1.b}), 0);
    chk("rst_err1", int'(err1), 0);
    chk("rst_busy2", int'(busy2), 0);
    chk("rst_err2", int'(err2), 0);
`ifdef COMPARATOR_BIST_FAILLOG_EN
    chk("rst_fv1", int'(fv1), 0);
`endif
    rst = 1'b0;

    // Table of fault models on the WIDTH=1, SETTLE=1 instance
    for (int i = 0; i < 5; i++) begin
      mode1 = tbl[i].mode;
      run(0, done_at, ndone, idle_at, ab_bad, pass0, busy0);
      chk($sformatf("t%0d_done_at", i), done_at, 12);
      chk($sformatf("t%0d_ndone", i), ndone, 1);
      chk($sformatf("t%0d_idle_at", i), idle_at, 13);
      chk($sformatf("t%0d_ab_seq", i), ab_bad, 0);
      chk($sformatf("t%0d_pass_cleared", i), pass0, 0);
      chk($sformatf("t%0d_busy_rise", i), busy0, 1);
      chk($sformatf("t%0d_err", i), int'(err1), tbl[i].err);
      chk($sformatf("t%0d_pass", i), int'(pass1), tbl[i].pass);
`ifdef COMPARATOR_BIST_FAILLOG_EN
      chk($sformatf("t%0d_fail_a", i), int'(fa1), tbl[i].fa);
      chk($sformatf("t%0d_fail_b", i), int'(fb1), tbl[i].fb);
      chk($sformatf("t%0d_fail_valid", i), int'(fv1), tbl[i].fv);
`endif
    end

    // start held high: a single done, then a fresh run only from IDLE
    mode1 = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    ndone = 0; done_at = -1; e = 0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      if (done1) begin ndone++; done_at = e; end
      if (e == 13) chk("hold_idle_busy", int'(busy1), 0);
      if (e == 14) chk("hold_restart_busy", int'(busy1), 1);
      @(posedge clk);
      e++;
    end
    chk("hold_ndone", ndone, 1);
    chk("hold_done_at", done_at, 12);
    @(negedge clk);
    start1 = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset mid-run at edge 5 with an all-ones responder
    mode1 = 2;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_err_before", int'(err1), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", int'(busy1), 0);
    chk("mid_ab", int'({bus1.a, bus1.b}), 0);
    chk("mid_err", int'(err1), 0);
    ndone = 0;
    e = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done1) ndone++;
      if (busy1) e++;
    end
    chk("mid_no_done", ndone, 0);
    chk("mid_stays_idle", e, 0);

    // WIDTH=2, SETTLE=0: correct model first, then random fault tables
    for (int r = 0; r < 5; r++) begin
      mode2 = (r == 0) ? 0 : 5;
      for (int i = 0; i < 16; i++)
        flt2[i] = (r == 0 || $urandom_range(3, 0) != 0) ? 3'b000 : 3'($urandom_range(7, 1));
      exp_err = 0;
      first_v = -1;
      for (int v = 0; v < 16; v++) begin
        if (model(mode2, v / 4, v % 4, flt2[v]) != golden(v / 4, v % 4)) begin
          exp_err++;
          if (first_v < 0) first_v = v;
        end
      end
      run(1, done_at, ndone, idle_at, ab_bad, pass0, busy0);
      chk($sformatf("w2r%0d_done_at", r), done_at, 32);
      chk($sformatf("w2r%0d_ndone", r), ndone, 1);
      chk($sformatf("w2r%0d_idle_at", r), idle_at, 33);
      chk($sformatf("w2r%0d_ab_seq", r), ab_bad, 0);
      chk($sformatf("w2r%0d_pass_cleared", r), pass0, 0);
      chk($sformatf("w2r%0d_err", r), int'(err2), exp_err);
      chk($sformatf("w2r%0d_pass", r), int'(pass2), (exp_err == 0) ? 1 : 0);
`ifdef COMPARATOR_BIST_FAILLOG_EN
      chk($sformatf("w2r%0d_fail_valid", r), int'(fv2), (first_v >= 0) ? 1 : 0);
      chk($sformatf("w2r%0d_fail_ab", r), int'({fa2, fb2}), (first_v >= 0) ? first_v : 0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
